// File: rtl/delay_sched.sv
// delay_sched: timed delay-length scheduler. Queues {time,len} commands and
// drives the delay stage len once the monitored beat count reaches each time.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   clear             synchronous flush of queue, head and sample_count (len kept)
//   cmd_tdata         {time, len} command, time in the MSBs
//   cmd_tvalid        command valid
//   cmd_tready        queue not full
//   mon_tvalid        tap of delay stage output valid
//   mon_tready        tap of delay stage output ready
//   len               registered delay length to the delay stage
//   sample_count      registered count of completed output beats
//   applied           one-cycle pulse when a command takes effect
//   late              one-cycle pulse with applied when the time had passed
//   pending           queued entries, not counting the head
module delay_sched #(
  parameter int MAX_LEN_LOG2    = 10,
  parameter int TIME_WIDTH      = 32,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clear,
  input  logic [TIME_WIDTH+MAX_LEN_LOG2-1:0] cmd_tdata,
  input  logic                              cmd_tvalid,
  output logic                              cmd_tready,
  input  logic                              mon_tvalid,
  input  logic                              mon_tready,
  output logic [MAX_LEN_LOG2-1:0]           len,
  output logic [TIME_WIDTH-1:0]             sample_count,
  output logic                              applied,
  output logic                              late,
  output logic [FIFO_DEPTH_LOG2:0]          pending
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int PW    = FIFO_DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT
  } state_t;

  state_t state;

  logic [TIME_WIDTH-1:0]   fifo_time [DEPTH];
  logic [MAX_LEN_LOG2-1:0] fifo_len  [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [TIME_WIDTH-1:0]   head_time;
  logic [MAX_LEN_LOG2-1:0] head_len;

  logic                  push;
  logic                  pop;
  logic                  beat;
  logic [TIME_WIDTH-1:0] diff;
  logic                  due;

  assign cmd_tready = reset | (count != CW'(DEPTH));
  assign push       = cmd_tvalid & cmd_tready;
  assign pop        = (state == LOAD);
  assign beat       = mon_tvalid & mon_tready;
  assign pending    = count;

  // Wrapping difference: anything within half the time range behind the
  // current sample counts as due.
  assign diff = sample_count - head_time;
  assign due  = ~diff[TIME_WIDTH-1];

  always_ff @(posedge clk) begin
    if (push && !reset && !clear) begin
      fifo_time[wr_ptr] <= cmd_tdata[TIME_WIDTH+MAX_LEN_LOG2-1:MAX_LEN_LOG2];
      fifo_len[wr_ptr]  <= cmd_tdata[MAX_LEN_LOG2-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      head_time    <= '0;
      head_len     <= '0;
      sample_count <= '0;
      applied      <= 1'b0;
      late         <= 1'b0;
      if (reset) len <= '0;
    end else begin
      applied <= 1'b0;
      late    <= 1'b0;
      if (beat) sample_count <= sample_count + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      unique case (state)
        IDLE: begin
          if (count != '0) state <= LOAD;
        end
        LOAD: begin
          head_time <= fifo_time[rd_ptr];
          head_len  <= fifo_len[rd_ptr];
          rd_ptr    <= rd_ptr + 1'b1;
          state     <= WAIT;
        end
        WAIT: begin
          if (due) begin
            len     <= head_len;
            applied <= 1'b1;
            late    <= (diff != '0);
            state   <= (count != '0) ? LOAD : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_sched.sv
// tb_delay_sched: directed self-checking bench for delay_sched.
// Main instance uses default widths; a narrow-time instance covers wrap.
module tb_delay_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        clear;
  logic [41:0] cmd_tdata;
  logic        cmd_tvalid;
  logic        cmd_tready;
  logic        mon_tvalid;
  logic        mon_tready;
  logic [9:0]  len;
  logic [31:0] sample_count;
  logic        applied;
  logic        late;
  logic [2:0]  pending;

  logic        w_clear;
  logic [17:0] w_cmd_tdata;
  logic        w_cmd_tvalid;
  logic        w_cmd_tready;
  logic        w_mon_tvalid;
  logic        w_mon_tready;
  logic [9:0]  w_len;
  logic [7:0]  w_sample_count;
  logic        w_applied;
  logic        w_late;
  logic [2:0]  w_pending;

  delay_sched dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .cmd_tdata    (cmd_tdata),
    .cmd_tvalid   (cmd_tvalid),
    .cmd_tready   (cmd_tready),
    .mon_tvalid   (mon_tvalid),
    .mon_tready   (mon_tready),
    .len          (len),
    .sample_count (sample_count),
    .applied      (applied),
    .late         (late),
    .pending      (pending)
  );

  delay_sched #(.TIME_WIDTH(8)) dut_w (
    .clk          (clk),
    .reset        (reset),
    .clear        (w_clear),
    .cmd_tdata    (w_cmd_tdata),
    .cmd_tvalid   (w_cmd_tvalid),
    .cmd_tready   (w_cmd_tready),
    .mon_tvalid   (w_mon_tvalid),
    .mon_tready   (w_mon_tready),
    .len          (w_len),
    .sample_count (w_sample_count),
    .applied      (w_applied),
    .late         (w_late),
    .pending      (w_pending)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] t, input logic [9:0] l);
    cmd_tdata  = {t, l};
    cmd_tvalid = 1'b1;
    step();
    cmd_tvalid = 1'b0;
  endtask

  initial begin
    int found;
    int napp;
    int anyapp;
    reset        = 1'b1;
    clear        = 1'b0;
    cmd_tdata    = '0;
    cmd_tvalid   = 1'b0;
    mon_tvalid   = 1'b0;
    mon_tready   = 1'b0;
    w_clear      = 1'b0;
    w_cmd_tdata  = '0;
    w_cmd_tvalid = 1'b0;
    w_mon_tvalid = 1'b0;
    w_mon_tready = 1'b0;
    step();
    chk("rst_tready", cmd_tready, 1);
    step();
    reset = 1'b0;
    step();
    chk("rst_len", len, 0);
    chk("rst_sc", sample_count, 0);
    chk("rst_applied", applied, 0);
    chk("rst_late", late, 0);
    chk("rst_pending", pending, 0);
    chk("rst_tready2", cmd_tready, 1);

    // on-time apply at T=10
    push(32'd10, 10'd5);
    step();
    step();
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      step();
      if (sample_count == 32'd10) found = 1;
    end
    chk("t1_reach10", found, 1);
    chk("t1_len_before", len, 0);
    chk("t1_app_before", applied, 0);
    step();
    chk("t1_len", len, 5);
    chk("t1_applied", applied, 1);
    chk("t1_late", late, 0);
    chk("t1_pending", pending, 0);
    step();
    chk("t1_pulse_end", applied, 0);

    // late command
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      step();
      if (sample_count == 32'd20) found = 1;
    end
    mon_tvalid = 1'b0;
    chk("t2_reach20", found, 1);
    push(32'd3, 10'd7);
    chk("t2_app_n", applied, 0);
    step();
    chk("t2_app_n1", applied, 0);
    step();
    chk("t2_app_n2", applied, 0);
    chk("t2_len_n2", len, 5);
    step();
    chk("t2_len", len, 7);
    chk("t2_applied", applied, 1);
    chk("t2_late", late, 1);
    step();
    chk("t2_late_end", late, 0);

    // stall around T=50
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_sc", sample_count, 0);
    chk("clr_len", len, 7);
    push(32'd50, 10'd9);
    step();
    step();
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      step();
      if (sample_count == 32'd49) found = 1;
    end
    chk("t4_reach49", found, 1);
    mon_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_stall_sc", sample_count, 49);
      chk("t4_stall_len", len, 7);
    end
    mon_tready = 1'b1;
    step();
    chk("t4_sc50", sample_count, 50);
    chk("t4_len_before", len, 7);
    step();
    chk("t4_len", len, 9);
    chk("t4_applied", applied, 1);
    chk("t4_late", late, 0);
    mon_tvalid = 1'b0;

    // fill the queue
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_tready_pre", cmd_tready, 1);
      cmd_tdata  = {32'(100 + i), 10'(i + 1)};
      cmd_tvalid = 1'b1;
      step();
    end
    cmd_tvalid = 1'b0;
    chk("t3_full", cmd_tready, 0);
    chk("t3_pending", pending, 4);
    anyapp = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (applied) anyapp = 1;
    end
    chk("t3_no_apply", anyapp, 0);
    chk("t3_pending2", pending, 4);
    mon_tvalid = 1'b1;
    napp = 0;
    for (int i = 0; i < 130; i++) begin
      step();
      if (applied) napp++;
    end
    mon_tvalid = 1'b0;
    chk("t3_napplied", napp, 5);
    chk("t3_len", len, 5);
    chk("t3_pending3", pending, 0);
    chk("t3_tready", cmd_tready, 1);

    // clear with head in WAIT
    push(32'd1000, 10'd3);
    push(32'd1001, 10'd4);
    step();
    step();
    chk("t6_pending_pre", pending, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t6_pending", pending, 0);
    chk("t6_sc", sample_count, 0);
    chk("t6_len", len, 5);
    chk("t6_applied", applied, 0);
    chk("t6_tready", cmd_tready, 1);
    anyapp = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (applied) anyapp = 1;
    end
    chk("t6_no_apply", anyapp, 0);
    chk("t6_pending2", pending, 0);

    // wrap on the 8-bit time instance
    w_mon_tvalid = 1'b1;
    w_mon_tready = 1'b1;
    for (int i = 0; i < 254; i++) step();
    w_mon_tvalid = 1'b0;
    chk("w_sc254", w_sample_count, 254);
    w_cmd_tdata  = {8'd1, 10'd12};
    w_cmd_tvalid = 1'b1;
    step();
    w_cmd_tvalid = 1'b0;
    step();
    step();
    chk("w_wait_app", w_applied, 0);
    w_mon_tvalid = 1'b1;
    step();
    chk("w_sc255", w_sample_count, 255);
    chk("w_app255", w_applied, 0);
    step();
    chk("w_sc0", w_sample_count, 0);
    chk("w_app_at255", w_applied, 0);
    chk("w_late_at255", w_late, 0);
    step();
    chk("w_sc1", w_sample_count, 1);
    chk("w_app_at0", w_applied, 0);
    w_mon_tvalid = 1'b0;
    step();
    chk("w_applied", w_applied, 1);
    chk("w_late", w_late, 0);
    chk("w_len", w_len, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
